// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit
// Description : Captures Z/V/N flags from EX-stage results and resolves
//               3-bit branch conditions into a registered taken/resolved pair.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_branch_unit #(
    parameter int WIDTH  = 16,
    parameter int FWD_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             wr_valid,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] result,
    input  logic             ovfl,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             br_resolved,
    output logic             br_taken,
    output logic             haz_stall
);

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0010;

    logic r_flag_z, r_flag_v, r_flag_n;
    logic r_br_resolved, r_br_taken;
    logic w_op_vn, w_op_z;
    logic w_wr_vn, w_wr_z;
    logic w_z_new, w_n_new;
    logic w_fz, w_fv, w_fn;
    logic w_haz;
    logic w_cond;

    // ADD/SUB write all three flags; logic and shift classes write Z only.
    assign w_op_vn = (opcode == c_OP_ADD) || (opcode == c_OP_SUB);
    assign w_op_z  = w_op_vn || ((opcode >= 4'd3) && (opcode <= 4'd7));
    assign w_wr_vn = wr_valid & ~stall & w_op_vn;
    assign w_wr_z  = wr_valid & ~stall & w_op_z;
    assign w_z_new = (result == '0);
    assign w_n_new = result[WIDTH-1];

    generate
        if (FWD_EN != 0) begin : g_fwd
            assign w_fz  = w_wr_z  ? w_z_new : r_flag_z;
            assign w_fv  = w_wr_vn ? ovfl    : r_flag_v;
            assign w_fn  = w_wr_vn ? w_n_new : r_flag_n;
            assign w_haz = 1'b0;
        end else begin : g_no_fwd
            assign w_fz  = r_flag_z;
            assign w_fv  = r_flag_v;
            assign w_fn  = r_flag_n;
            assign w_haz = br_valid & wr_valid & w_op_z;
        end
    endgenerate

    always_comb begin
        w_cond = 1'b0;
        case (br_cond)
            3'b000:  w_cond = ~w_fz;
            3'b001:  w_cond = w_fz;
            3'b010:  w_cond = ~w_fz & ~w_fn;
            3'b011:  w_cond = w_fn;
            3'b100:  w_cond = w_fz | ~w_fn;
            3'b101:  w_cond = w_fn | w_fz;
            3'b110:  w_cond = w_fv;
            default: w_cond = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_z <= 1'b0;
            r_flag_v <= 1'b0;
            r_flag_n <= 1'b0;
        end else begin
            if (w_wr_z) begin
                r_flag_z <= w_z_new;
            end
            if (w_wr_vn) begin
                r_flag_v <= ovfl;
                r_flag_n <= w_n_new;
            end
        end
    end

    // Flush only kills the branch; the older flag writer above still commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_resolved <= 1'b0;
            r_br_taken    <= 1'b0;
        end else if (!stall) begin
            if (flush) begin
                r_br_resolved <= 1'b0;
                r_br_taken    <= 1'b0;
            end else if (br_valid && !w_haz) begin
                r_br_resolved <= 1'b1;
                r_br_taken    <= w_cond;
            end else begin
                r_br_resolved <= 1'b0;
                r_br_taken    <= 1'b0;
            end
        end
    end

    assign flag_z      = r_flag_z;
    assign flag_v      = r_flag_v;
    assign flag_n      = r_flag_n;
    assign br_resolved = r_br_resolved;
    assign br_taken    = r_br_taken;
    assign haz_stall   = w_haz;

endmodule
`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_branch_unit
// Description : Scoreboard bench driving a forwarding and a stalling instance
//               of flag_branch_unit from the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_branch_unit;

    typedef struct packed {
        logic        wv;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ov;
        logic        bv;
        logic [2:0]  bc;
        logic        st;
        logic        fl;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, wr_valid = 1'b0, ovfl = 1'b0, br_valid = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [15:0] result = 16'd0;
    logic [2:0]  br_cond = 3'd0;

    logic f_z, f_v, f_n, f_res, f_tak, f_haz;
    logic n_z, n_v, n_n, n_res, n_tak, n_haz;

    int n_checks = 0;
    int n_errors = 0;

    logic m_z, m_v, m_n, m_rf, m_tf, m_rn, m_tn;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    flag_branch_unit #(.WIDTH(16), .FWD_EN(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .wr_valid(wr_valid), .opcode(opcode), .result(result), .ovfl(ovfl),
        .br_valid(br_valid), .br_cond(br_cond),
        .flag_z(f_z), .flag_v(f_v), .flag_n(f_n),
        .br_resolved(f_res), .br_taken(f_tak), .haz_stall(f_haz)
    );

    flag_branch_unit #(.WIDTH(16), .FWD_EN(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .wr_valid(wr_valid), .opcode(opcode), .result(result), .ovfl(ovfl),
        .br_valid(br_valid), .br_cond(br_cond),
        .flag_z(n_z), .flag_v(n_v), .flag_n(n_n),
        .br_resolved(n_res), .br_taken(n_tak), .haz_stall(n_haz)
    );

    function automatic stim_t mk(input logic wv, input logic [3:0] op, input logic [15:0] res,
                                 input logic ov, input logic bv, input logic [2:0] bc,
                                 input logic st, input logic fl);
        stim_t s;
        s.wv = wv; s.op = op; s.res = res; s.ov = ov;
        s.bv = bv; s.bc = bc; s.st = st; s.fl = fl;
        return s;
    endfunction

    function automatic logic cond_eval(input logic [2:0] c, input logic z, input logic v, input logic n);
        case (c)
            3'd0:    return ~z;
            3'd1:    return z;
            3'd2:    return ~z & ~n;
            3'd3:    return n;
            3'd4:    return z | ~n;
            3'd5:    return n | z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_z = 0; m_v = 0; m_n = 0; m_rf = 0; m_tf = 0; m_rn = 0; m_tn = 0;
        exp_q.delete();
    endtask

    // Apply one cycle of stimulus and push the post-edge expectation.
    task automatic drive(input stim_t s, output logic haz_e);
        logic wa, wvn, w, zn, fz, fv, fn, cf, cn;
        stall = s.st; flush = s.fl; wr_valid = s.wv; opcode = s.op;
        result = s.res; ovfl = s.ov; br_valid = s.bv; br_cond = s.bc;
        wa  = (s.op == 4'd0) || (s.op == 4'd2) || (s.op >= 4'd3 && s.op <= 4'd7);
        wvn = (s.op == 4'd0) || (s.op == 4'd2);
        w   = s.wv & ~s.st;
        zn  = (s.res == 16'd0);
        fz  = (w & wa)  ? zn        : m_z;
        fv  = (w & wvn) ? s.ov      : m_v;
        fn  = (w & wvn) ? s.res[15] : m_n;
        cf  = cond_eval(s.bc, fz, fv, fn);
        cn  = cond_eval(s.bc, m_z, m_v, m_n);
        haz_e = s.bv & s.wv & wa;
        if (!s.st) begin
            if (s.fl) begin
                m_rf = 0; m_tf = 0; m_rn = 0; m_tn = 0;
            end else begin
                m_rf = s.bv; m_tf = s.bv & cf;
                m_rn = s.bv & ~haz_e; m_tn = m_rn & cn;
            end
        end
        if (w & wa) m_z = zn;
        if (w & wvn) begin m_v = s.ov; m_n = s.res[15]; end
        exp_q.push_back({m_z, m_v, m_n, m_z, m_v, m_n, m_rf, m_tf, m_rn, m_tn});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({f_z, f_v, f_n, f_res, f_tak, n_z, n_v, n_n, n_res, n_tak} !== 10'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {f_z, f_v, f_n, f_res, f_tak, n_z, n_v, n_n, n_res, n_tak}, 10'b0);
        end
        n_checks++;
        if ({f_haz, n_haz} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_haz_idle: got %b expected 00", {f_haz, n_haz});
        end
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_add_zero();
        stim_t rows[$];
        logic he; logic [9:0] e;
        rows.push_back(mk(1, 4'd0, 16'h0000, 0, 0, 3'd0, 0, 0));
        rows.push_back(mk(0, 4'd0, 16'h0000, 0, 1, 3'd1, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i], he); #1;
            n_checks++;
            if ({f_haz, n_haz} !== {1'b0, he}) begin
                n_errors++;
                $display("FAIL add_zero[%0d] haz: got %b expected %b", i, {f_haz, n_haz}, {1'b0, he});
            end
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak} !== e) begin
                n_errors++;
                $display("FAIL add_zero[%0d] zvn/zvn/rt/rt: got %b expected %b", i,
                         {f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak}, e);
            end
        end
    endtask

    task automatic test_sub_and();
        stim_t rows[$];
        logic he; logic [9:0] e;
        rows.push_back(mk(1, 4'd2, 16'h8000, 1, 0, 3'd0, 0, 0));
        rows.push_back(mk(1, 4'd3, 16'h0001, 0, 0, 3'd0, 0, 0));
        rows.push_back(mk(0, 4'd0, 16'h0000, 0, 1, 3'd6, 0, 0));
        rows.push_back(mk(0, 4'd0, 16'h0000, 0, 1, 3'd2, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i], he); #1;
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak} !== e) begin
                n_errors++;
                $display("FAIL sub_and[%0d] zvn/zvn/rt/rt: got %b expected %b", i,
                         {f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak}, e);
            end
        end
    endtask

    task automatic test_forward();
        stim_t rows[$];
        logic he; logic [9:0] e;
        rows.push_back(mk(1, 4'd0, 16'h0000, 0, 0, 3'd0, 0, 0));
        rows.push_back(mk(1, 4'd0, 16'h0005, 0, 1, 3'd2, 0, 0));
        rows.push_back(mk(0, 4'd0, 16'h0000, 0, 1, 3'd2, 0, 0));
        rows.push_back(mk(1, 4'd7, 16'h0000, 0, 1, 3'd1, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i], he); #1;
            n_checks++;
            if ({f_haz, n_haz} !== {1'b0, he}) begin
                n_errors++;
                $display("FAIL forward[%0d] haz: got %b expected %b", i, {f_haz, n_haz}, {1'b0, he});
            end
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak} !== e) begin
                n_errors++;
                $display("FAIL forward[%0d] zvn/zvn/rt/rt: got %b expected %b", i,
                         {f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak}, e);
            end
        end
    endtask

    task automatic test_paddsb();
        stim_t rows[$];
        logic he; logic [9:0] e;
        rows.push_back(mk(1, 4'd2,    16'h8000, 0, 0, 3'd0, 0, 0));
        rows.push_back(mk(1, 4'd1,    16'h0000, 1, 1, 3'd3, 0, 0));
        rows.push_back(mk(1, 4'b1010, 16'h0000, 1, 0, 3'd0, 0, 0));
        rows.push_back(mk(0, 4'd0,    16'h0000, 0, 1, 3'd3, 0, 0));
        rows.push_back(mk(1, 4'd5,    16'h8000, 1, 1, 3'd5, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i], he); #1;
            n_checks++;
            if ({f_haz, n_haz} !== {1'b0, he}) begin
                n_errors++;
                $display("FAIL paddsb[%0d] haz: got %b expected %b", i, {f_haz, n_haz}, {1'b0, he});
            end
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak} !== e) begin
                n_errors++;
                $display("FAIL paddsb[%0d] zvn/zvn/rt/rt: got %b expected %b", i,
                         {f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak}, e);
            end
        end
    endtask

    task automatic test_stall_flush();
        stim_t rows[$];
        logic he; logic [9:0] e;
        rows.push_back(mk(0, 4'd0, 16'h0000, 0, 1, 3'd7, 0, 0));
        repeat (3) rows.push_back(mk(1, 4'd0, 16'h0000, 1, 1, 3'd1, 1, 0));
        rows.push_back(mk(1, 4'd0, 16'h0000, 1, 1, 3'd7, 0, 1));
        rows.push_back(mk(0, 4'd0, 16'h0000, 0, 1, 3'd7, 0, 0));
        rows.push_back(mk(1, 4'd2, 16'hffff, 0, 1, 3'd7, 1, 1));
        rows.push_back(mk(0, 4'd0, 16'h0000, 0, 0, 3'd0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i], he); #1;
            n_checks++;
            if ({f_haz, n_haz} !== {1'b0, he}) begin
                n_errors++;
                $display("FAIL stall_flush[%0d] haz: got %b expected %b", i, {f_haz, n_haz}, {1'b0, he});
            end
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak} !== e) begin
                n_errors++;
                $display("FAIL stall_flush[%0d] zvn/zvn/rt/rt: got %b expected %b", i,
                         {f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak}, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t rows[$];
        logic he; logic [9:0] e;
        rows.push_back(mk(1, 4'd0, 16'hfffe, 0, 0, 3'd0, 0, 0));
        for (int c = 0; c < 8; c++) rows.push_back(mk(0, 4'd0, 16'h0000, 0, 1, 3'(c), 0, 0));
        rows.push_back(mk(1, 4'd6, 16'h0000, 0, 0, 3'd0, 0, 0));
        for (int c = 0; c < 8; c++) rows.push_back(mk(0, 4'd0, 16'h0000, 0, 1, 3'(c), 0, 0));
        rows.push_back(mk(0, 4'd0, 16'h0000, 0, 0, 3'd0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i], he); #1;
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak} !== e) begin
                n_errors++;
                $display("FAIL back_to_back[%0d] zvn/zvn/rt/rt: got %b expected %b", i,
                         {f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak}, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic he; logic [9:0] e;
        drive(mk(1, 4'd2, 16'h8000, 1, 1, 3'd7, 0, 0), he); #1;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if ({f_res, f_tak, n_res, n_tak} !== e[3:0]) begin
            n_errors++;
            $display("FAIL async_reset_pre: got %b expected %b", {f_res, f_tak, n_res, n_tak}, e[3:0]);
        end
        drive(mk(0, 4'd0, 16'h0000, 0, 0, 3'd0, 0, 0), he);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({f_z, f_v, f_n, f_res, f_tak, n_z, n_v, n_n, n_res, n_tak} !== 10'b0) begin
            n_errors++;
            $display("FAIL async_reset_clear: got %b expected %b",
                     {f_z, f_v, f_n, f_res, f_tak, n_z, n_v, n_n, n_res, n_tak}, 10'b0);
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        drive(mk(0, 4'd0, 16'h0000, 0, 1, 3'd7, 0, 0), he); #1;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if ({f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak} !== e) begin
            n_errors++;
            $display("FAIL async_reset_uncond: got %b expected %b",
                     {f_z, f_v, f_n, n_z, n_v, n_n, f_res, f_tak, n_res, n_tak}, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_add_zero();
        test_sub_and();
        test_forward();
        test_paddsb();
        test_stall_flush();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer end of the arithmetic unit's result path: captures Z/V/N condition flags from AU/ALU results in the EX stage.
- Evaluates 3-bit branch conditions against those flags and produces a registered taken/resolved pair for the fetch stage.
- Handles the same-cycle writer/branch hazard by forwarding (or, when forwarding is disabled, by requesting a stall), and supports pipeline stall and flush.

Parameters:
WIDTH, 16, datapath width of result input
FWD_EN, 1, 1 = forward same-cycle flag update to branch evaluation; 0 = raise haz_stall instead

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline hold; no state changes while high
flush  in  1  kill in-flight branch evaluation
wr_valid  in  1  result/opcode/ovfl valid this cycle
opcode  in  4  instruction class of the result
result  in  WIDTH  final (saturated) AU/ALU result
ovfl  in  1  overflow indication from AU for ADD/SUB
br_valid  in  1  branch needing evaluation this cycle
br_cond  in  3  condition code
flag_z  out  1  zero flag
flag_v  out  1  overflow flag
flag_n  out  1  negative flag
br_resolved  out  1  pulse: branch outcome valid
br_taken  out  1  outcome, qualified by br_resolved
haz_stall  out  1  combinational stall request (FWD_EN=0 only)

Behaviour:
- Reset (rst_n low, async): flag_z=0, flag_v=0, flag_n=0, br_resolved=0, br_taken=0. haz_stall is combinational; 0 when its inputs are idle.
- Flag write when wr_valid & ~stall:
  - opcode 0000 ADD / 0010 SUB: Z=(result==0), V=ovfl, N=result[WIDTH-1].
  - 0011 AND, 0100 NOR, 0101 SLL, 0110 SRL, 0111 SRA: Z only; V and N hold.
  - 0001 PADDSB and 1xxx: no flag change.
- Z is defined as all-zero result (active high). It is not the OR-reduction of the result.
- Effective flags (fZ/fV/fN):
  - FWD_EN=1: the value being written this cycle if a flag write occurs, else the registered flags.
  - FWD_EN=0: registered flags only.
- Condition decode:
  - 000 NEQ: ~fZ
  - 001 EQ: fZ
  - 010 GT: ~fZ & ~fN
  - 011 LT: fN
  - 100 GTE: fZ | ~fN
  - 101 LTE: fN | fZ
  - 110 OV: fV
  - 111 UNCOND: 1
- Hazard (FWD_EN=0): haz_stall = br_valid & wr_valid & opcode writes any flag. While haz_stall is high, the branch is not evaluated. Always 0 when FWD_EN=1.
- Output register update, per cycle:
  - stall high: br_resolved and br_taken hold.
  - else flush high: br_resolved<=0, br_taken<=0. Flag writes still occur; the writer is older than the flushed branch.
  - else br_valid & ~haz_stall: br_resolved<=1, br_taken<=cond.
  - else: br_resolved<=0, br_taken<=0.
- Latency: one cycle from br_valid to br_resolved. br_resolved never high two cycles unless consecutive branches are issued or stall holds it.
- Simultaneous flush & stall: stall wins (everything holds).
- Reset mid-operation clears any pending resolution immediately.
- Width rules: only result[WIDTH-1] and the zero test are used. ovfl is ignored for non-ADD/SUB opcodes.

Test Plan:
- Reset, then ADD result=16'h0000 ovfl=0 -> next cycle flag_z=1 flag_v=0 flag_n=0. Follow with br_cond=001 -> br_resolved=1 br_taken=1.
- SUB result=16'h8000 ovfl=1, then AND result=16'h0001 -> Z=0, V=1 and N=1 retained. br_cond=110 -> taken=1. br_cond=010 -> taken=0.
- FWD_EN=1: same cycle ADD result=16'h0005 and br_valid br_cond=010, registered Z=1 -> br_taken=1 (forwarded). FWD_EN=0, same stimulus -> haz_stall=1, no br_resolved that cycle.
- PADDSB result=16'h0000 with flags Z=0 N=1 -> flags unchanged. br_cond=011 -> taken=1.
- br_valid with stall=1 for 3 cycles -> br_resolved unchanged throughout. br_valid with flush=1 -> br_resolved=0 next cycle. flush+stall together -> hold.
- rst_n pulsed low asynchronously while br_resolved=1 -> all outputs 0 without waiting for a clock edge. br_cond=111 after release -> taken=1.
